// File: rtl/debug_reg_bank_pkg.sv
// Shared offsets, bit positions and decode helpers for the debug register bank.
// Everything here is in terms of the 8-bit offset inside the 256-byte window.
package debug_reg_bank_pkg;

   localparam logic [7:0] OFS_REG0      = 8'h00;
   localparam logic [7:0] OFS_MBOX_DATA = 8'h40;
   localparam logic [7:0] OFS_MBOX_STAT = 8'h44;
   localparam logic [7:0] OFS_CYCLE_CNT = 8'h48;
   localparam logic [7:0] OFS_CTRL      = 8'h4C;

   localparam int STAT_EMPTY = 16;
   localparam int STAT_FULL  = 17;
   localparam int STAT_OVF   = 18;

   localparam int CTRL_EN  = 0;
   localparam int CTRL_CLR = 1;

   typedef enum logic [2:0] {
      RGN_NONE,
      RGN_SCRATCH,
      RGN_MBOX_DATA,
      RGN_MBOX_STAT,
      RGN_CYCLE_CNT,
      RGN_CTRL
   } region_t;

   // Scratch registers occupy word-aligned offsets up to 4*num_regs; anything else unlisted is a hole.
   function automatic region_t decode_offset(input logic [7:0] ofs, input int num_regs);
      region_t rgn;
      rgn = RGN_NONE;
      if (ofs[1:0] == 2'b00 && (int'(ofs) - int'(OFS_REG0)) < 4 * num_regs) begin
         rgn = RGN_SCRATCH;
      end else begin
         case (ofs)
            OFS_MBOX_DATA: rgn = RGN_MBOX_DATA;
            OFS_MBOX_STAT: rgn = RGN_MBOX_STAT;
            OFS_CYCLE_CNT: rgn = RGN_CYCLE_CNT;
            OFS_CTRL:      rgn = RGN_CTRL;
            default:       rgn = RGN_NONE;
         endcase
      end
      return rgn;
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/debug_mbox_fifo.sv
// Byte-wide mailbox FIFO with combinational head output and an explicit occupancy count.
// Pushes while full and pops while empty are ignored here; the bank tracks overflow itself.
module debug_mbox_fifo #(
   parameter int DEPTH = 8,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // DEPTH is a power of two, so the pointers wrap simply by overflowing.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/debug_reg_bank.sv
// Wishbone debug register bank: scratch registers, a byte mailbox and a cycle counter.
// Every hit inside the window is acked one cycle later, so firmware never stalls on a bad offset.
module debug_reg_bank
   import debug_reg_bank_pkg::*;
#(
   parameter int          NUM_REGS   = 2,
   parameter logic [31:0] REG0_RST   = 32'h0,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          FIFO_DEPTH = 8,
   localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  wbs_stb_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_we_i,
   input  logic [3:0]            wbs_sel_i,
   input  logic [31:0]           wbs_dat_i,
   input  logic [31:0]           wbs_adr_i,
   output logic                  wbs_ack_o,
   output logic [31:0]           wbs_dat_o,
   output logic [NUM_REGS*32-1:0] dbg_regs_o,
   output logic [LVL_W-1:0]      mbox_level_o
);

   logic             ack;
   logic [31:0]      dat;
   logic             hit;
   logic             wr;
   logic             rd;
   logic [7:0]       ofs;
   logic [2:0]       reg_idx;
   region_t          region;
   logic [31:0]      rdata;

   logic [31:0]      regs [NUM_REGS];
   logic [31:0]      cnt;
   logic             en;
   logic             ovf;

   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_head;
   logic [LVL_W-1:0] level;
   logic             clr_req;
   logic             cnt_wr;

   assign ofs     = wbs_adr_i[7:0];
   assign reg_idx = ofs[4:2];
   assign region  = decode_offset(ofs, NUM_REGS);

   // Masking with !ack makes each access exactly one request cycle plus one ack cycle.
   assign hit = wbs_cyc_i & wbs_stb_i & ~ack & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign wr  = hit & wbs_we_i;
   assign rd  = hit & ~wbs_we_i;

   assign push    = wr && (region == RGN_MBOX_DATA) && wbs_sel_i[0] && !fifo_full;
   assign pop     = rd && (region == RGN_MBOX_DATA) && !fifo_empty;
   assign clr_req = wr && (region == RGN_CTRL) && wbs_sel_i[0] && wbs_dat_i[CTRL_CLR];
   assign cnt_wr  = wr && (region == RGN_CYCLE_CNT) && (wbs_sel_i != 4'b0000);

   debug_mbox_fifo #(
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LVL_W)
   ) u_mbox (
      .clock (wb_clk_i),
      .reset (wb_rst_i),
      .push  (push),
      .pop   (pop),
      .din   (wbs_dat_i[7:0]),
      .dout  (fifo_head),
      .level (level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      rdata = '0;
      case (region)
         RGN_SCRATCH: begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (reg_idx == 3'(i)) rdata = regs[i];
            end
         end
         RGN_MBOX_DATA: begin
            if (!fifo_empty) rdata = {1'b1, 23'b0, fifo_head};
         end
         RGN_MBOX_STAT: begin
            rdata[6:0]        = 7'(level);
            rdata[STAT_EMPTY] = fifo_empty;
            rdata[STAT_FULL]  = fifo_full;
            rdata[STAT_OVF]   = ovf;
         end
         RGN_CYCLE_CNT: rdata = cnt;
         RGN_CTRL:      rdata[CTRL_EN] = en;
         default:       rdata = '0;
      endcase
   end

   // Read data is sampled from pre-write state on the same edge that raises ack.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack <= 1'b0;
         dat <= '0;
      end else begin
         ack <= hit;
         dat <= rd ? rdata : '0;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= (i == 0) ? REG0_RST : '0;
         end
      end else if (wr && region == RGN_SCRATCH) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_idx == 3'(i)) regs[i] <= byte_merge(regs[i], wbs_dat_i, wbs_sel_i);
         end
      end
   end

   // Overflow is sticky until firmware writes 1 to its status bit.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ovf <= 1'b0;
      end else if (wr && region == RGN_MBOX_DATA && wbs_sel_i[0] && fifo_full) begin
         ovf <= 1'b1;
      end else if (wr && region == RGN_MBOX_STAT && wbs_sel_i[2] && wbs_dat_i[STAT_OVF]) begin
         ovf <= 1'b0;
      end
   end

   // Clear beats a load, and a load beats the free-running increment.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         cnt <= '0;
         en  <= 1'b1;
      end else begin
         if (clr_req) begin
            cnt <= '0;
         end else if (cnt_wr) begin
            cnt <= byte_merge(cnt, wbs_dat_i, wbs_sel_i);
         end else if (en) begin
            cnt <= cnt + 32'd1;
         end
         if (wr && region == RGN_CTRL && wbs_sel_i[0]) en <= wbs_dat_i[CTRL_EN];
      end
   end

   always_comb begin
      dbg_regs_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         dbg_regs_o[32*i +: 32] = regs[i];
      end
   end

   assign wbs_ack_o    = ack;
   assign wbs_dat_o    = dat;
   assign mbox_level_o = level;

endmodule

// File: tb/tb_debug_reg_bank.sv
// Bench for debug_reg_bank: directed steps then random accesses, all checked against
// a register/queue/arithmetic model of the bank.
module tb_debug_reg_bank;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk;
   logic        rst;
   logic        stb;
   logic        cyc;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] dat_i;
   logic [31:0] adr;
   logic        ack;
   logic [31:0] dat_o;
   logic [63:0] dbg_regs;
   logic [3:0]  level;

   int total;
   int bad;
   int tb_cyc;

   logic [31:0] m_regs [2];
   byte         m_q [$];
   bit          m_ovf;
   logic [31:0] m_base;
   int          m_base_edge;
   bit          m_en;

   debug_reg_bank #(
      .NUM_REGS   (2),
      .REG0_RST   (32'h1),
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (8)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .wbs_stb_i    (stb),
      .wbs_cyc_i    (cyc),
      .wbs_we_i     (we),
      .wbs_sel_i    (sel),
      .wbs_dat_i    (dat_i),
      .wbs_adr_i    (adr),
      .wbs_ack_o    (ack),
      .wbs_dat_o    (dat_o),
      .dbg_regs_o   (dbg_regs),
      .mbox_level_o (level)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst) begin
      if (rst) tb_cyc <= 0;
      else     tb_cyc <= tb_cyc + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_regs[0]   = 32'h1;
      m_regs[1]   = 32'h0;
      m_q.delete();
      m_ovf       = 1'b0;
      m_base      = 32'h0;
      m_base_edge = 0;
      m_en        = 1'b1;
   endfunction

   // Counter value right after posedge number k.
   function automatic logic [31:0] cnt_at(input int k);
      return m_en ? m_base + 32'(k - m_base_edge) : m_base;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] o, input int e);
      logic [31:0] r;
      r = 32'h0;
      if (o < 8'h08 && o[1:0] == 2'b00) r = m_regs[o[2]];
      else if (o == 8'h40) r = (m_q.size() > 0) ? {1'b1, 23'b0, m_q[0]} : 32'h0;
      else if (o == 8'h44) begin
         r[6:0] = 7'(m_q.size());
         r[16]  = (m_q.size() == 0);
         r[17]  = (m_q.size() == 8);
         r[18]  = m_ovf;
      end
      else if (o == 8'h48) r = cnt_at(e - 1);
      else if (o == 8'h4C) r = {31'b0, m_en};
      return r;
   endfunction

   function automatic void model_write(input logic [7:0] o, input logic [3:0] s, input logic [31:0] d, input int e);
      logic [31:0] v;
      if (o < 8'h08 && o[1:0] == 2'b00) m_regs[o[2]] = merge(m_regs[o[2]], d, s);
      else if (o == 8'h40 && s[0]) begin
         if (m_q.size() < 8) m_q.push_back(d[7:0]);
         else m_ovf = 1'b1;
      end
      else if (o == 8'h44 && s[2] && d[18]) m_ovf = 1'b0;
      else if (o == 8'h48 && s != 4'b0000) begin
         m_base      = merge(cnt_at(e - 1), d, s);
         m_base_edge = e;
      end
      else if (o == 8'h4C && s[0]) begin
         v           = d[1] ? 32'h0 : cnt_at(e);
         m_base      = v;
         m_base_edge = e;
         m_en        = d[0];
      end
   endfunction

   task automatic applyStimulus(input logic w, input logic [7:0] o, input logic [3:0] s,
                                input logic [31:0] d, output logic [31:0] rdat);
      int e;
      logic [31:0] exp;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat_i = d; adr = BASE | {24'h0, o};
      @(negedge clk);
      e   = tb_cyc;
      exp = model_read(o, e);
      checkOutput("ack_high", ack, 1);
      if (!w) checkOutput($sformatf("rdata_%02h", o), dat_o, exp);
      rdat = dat_o;
      if (w) model_write(o, s, d, e);
      else if (o == 8'h40 && m_q.size() > 0) void'(m_q.pop_front());
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      checkOutput("ack_low", ack, 0);
      checkOutput("idle_dat", dat_o, 0);
      checkOutput("level", level, 32'(m_q.size()));
      for (int i = 0; i < 2; i++) checkOutput($sformatf("dbg_reg%0d", i), dbg_regs[32*i +: 32], m_regs[i]);
   endtask

   initial begin
      logic [31:0] r;
      logic [7:0]  ofs_tab [9];
      logic [7:0]  o;
      logic        w;
      logic [3:0]  s;
      logic [31:0] d;

      ofs_tab = '{8'h00, 8'h04, 8'h08, 8'h20, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h41};
      total = 0; bad = 0;
      clk = 1'b0; rst = 1'b1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0; adr = '0;
      model_reset();
      repeat (3) @(negedge clk);
      checkOutput("rst_ack", ack, 0);
      checkOutput("rst_dat", dat_o, 0);
      checkOutput("rst_level", level, 0);
      checkOutput("rst_reg0", dbg_regs[31:0], 32'h1);
      checkOutput("rst_reg1", dbg_regs[63:32], 32'h0);
      rst = 1'b0;

      applyStimulus(0, 8'h00, 4'hF, 0, r); checkOutput("reg0_rst_read", r, 32'h1);
      applyStimulus(0, 8'h04, 4'hF, 0, r); checkOutput("reg1_rst_read", r, 32'h0);
      applyStimulus(0, 8'h48, 4'hF, 0, r);
      applyStimulus(0, 8'h48, 4'hF, 0, r);

      applyStimulus(1, 8'h04, 4'b0101, 32'hAABB_CCDD, r);
      applyStimulus(0, 8'h04, 4'hF, 0, r); checkOutput("byte_en_read", r, 32'h00BB_00DD);
      checkOutput("byte_en_dbg", dbg_regs[63:32], 32'h00BB_00DD);

      applyStimulus(1, 8'h40, 4'h1, 32'h48, r);
      applyStimulus(1, 8'h40, 4'h1, 32'h69, r);
      applyStimulus(0, 8'h44, 4'hF, 0, r); checkOutput("stat_two", r, 32'h0000_0002);
      applyStimulus(0, 8'h40, 4'hF, 0, r); checkOutput("pop_H", r, 32'h8000_0048);
      applyStimulus(0, 8'h40, 4'hF, 0, r); checkOutput("pop_i", r, 32'h8000_0069);
      applyStimulus(0, 8'h40, 4'hF, 0, r); checkOutput("pop_empty", r, 32'h0);
      for (int i = 0; i < 9; i++) applyStimulus(1, 8'h40, 4'h1, 32'h30 + 32'(i), r);
      applyStimulus(0, 8'h44, 4'hF, 0, r); checkOutput("stat_full_ovf", r, 32'h0006_0008);
      applyStimulus(1, 8'h44, 4'b0100, 32'h0004_0000, r);
      applyStimulus(0, 8'h44, 4'hF, 0, r); checkOutput("stat_w1c", r, 32'h0002_0008);
      for (int i = 0; i < 8; i++) applyStimulus(0, 8'h40, 4'hF, 0, r);
      checkOutput("last_kept_byte", r, 32'h8000_0037);

      applyStimulus(1, 8'h4C, 4'hF, 32'h0, r);
      applyStimulus(0, 8'h48, 4'hF, 0, r);
      applyStimulus(0, 8'h48, 4'hF, 0, r);
      applyStimulus(1, 8'h4C, 4'hF, 32'h2, r);
      applyStimulus(0, 8'h48, 4'hF, 0, r); checkOutput("cnt_cleared", r, 32'h0);
      applyStimulus(1, 8'h48, 4'hF, 32'hFFFF_FFFE, r);
      applyStimulus(1, 8'h4C, 4'hF, 32'h1, r);
      applyStimulus(0, 8'h48, 4'hF, 0, r); checkOutput("cnt_wrapped", 32'(r < 32'd16), 1);
      applyStimulus(0, 8'h4C, 4'hF, 0, r); checkOutput("ctrl_en", r, 32'h1);

      applyStimulus(0, 8'h20, 4'hF, 0, r); checkOutput("hole_read", r, 32'h0);

      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'h1; dat_i = 32'h55; adr = 32'h3100_0040;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("miss_no_ack", ack, 0);
         checkOutput("miss_dat", dat_o, 0);
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;

      for (int n = 0; n < 80; n++) begin
         o = ofs_tab[$urandom_range(0, 8)];
         w = 1'($urandom_range(0, 1));
         s = 4'($urandom);
         d = $urandom;
         if (o == 8'h48 && s == 4'h0) s = 4'hF;
         if (o == 8'h4C && $urandom_range(0, 3) != 0) d[0] = 1'b1;
         applyStimulus(w, o, s, d, r);
      end

      for (int i = 0; i < 3; i++) applyStimulus(1, 8'h40, 4'h1, 32'hA0 + 32'(i), r);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_ack", ack, 0);
      checkOutput("mid_rst_level", level, 0);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      checkOutput("post_rst_level", level, 0);
      applyStimulus(0, 8'h44, 4'hF, 0, r); checkOutput("post_rst_stat", r, 32'h0001_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/debug_reg_bank.md
Name: debug_reg_bank

Overview:
Parametrised debug register bank on the user-project Wishbone slave port. Firmware and the cocotb testbench use it to exchange state.
- NUM_REGS general 32-bit scratch registers with byte-enable writes.
- A byte mailbox FIFO for firmware "printf"-style messages.
- A 32-bit cycle counter with an enable/clear control register.
- Decodes a 256-byte window at BASE_ADDR. It always acks inside the window, so the bus never hangs on a bad offset.

Parameters:
- NUM_REGS, 2, number of scratch registers; legal range 1..8.
- REG0_RST, 32'h0, reset value of scratch reg 0 (PDK flag; sky builds set 1); all other regs reset to 0.
- BASE_ADDR, 32'h3000_0000, window base; only bits [31:8] are compared.
- FIFO_DEPTH, 8, mailbox depth; power of 2, range 2..64.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  registered ack.
- wbs_dat_o  out  32  registered read data.
- dbg_regs_o  out  NUM_REGS*32  flattened scratch registers (reg i at [32i+31:32i]), for testbench observation.
- mbox_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Clock and reset: reset is wb_rst_i, asynchronous, active-high; clock is wb_clk_i. Everything is reset by wb_rst_i.
- Reset values:
  - ack=0, dat_o=0.
  - reg0=REG0_RST, other regs 0.
  - FIFO empty, overflow=0.
  - counter=0, ctrl.en=1.
- Hit: cyc & stb & !ack & adr[31:8]==BASE_ADDR[31:8].
- Ack timing:
  - On a hit, ack is asserted the next cycle for exactly 1 cycle. Write side effects occur on that same edge.
  - ack drops the following cycle, so each access costs 2 cycles. Back-to-back requests are acked every other cycle.
- Idle: when not acking, dat_o=0.
- Misses: no ack, no side effects.
- Offset map (adr[7:0]):
  - 0x00+4i: scratch reg i, i<NUM_REGS. Read/write with per-byte sel.
  - 0x40 MBOX_DATA:
    - Write with sel[0] pushes dat_i[7:0]. If full, the byte is dropped and the sticky overflow bit is set.
    - Read returns {1'b1,23'b0,head} and pops when non-empty. When empty it returns 0 and does not pop.
  - 0x44 MBOX_STAT, read: [6:0]=level zero-extended, [16]=empty, [17]=full, [18]=overflow. Write with sel[2] & dat_i[18]=1 clears overflow (W1C). Other bits ignored.
  - 0x48 CYCLE_CNT:
    - Increments by 1 every cycle while ctrl.en=1 and wraps 0xFFFF_FFFF -> 0.
    - Write loads the selected bytes.
    - If a write coincides with an increment, the write wins.
  - 0x4C CTRL: [0]=en (R/W); [1]=clear (write-1, self-clearing, reads 0). A clear zeroes the counter on the ack edge and takes priority over increment and en.
  - Unmapped offsets in the window (including i>=NUM_REGS): ack, read 0, write ignored.
- Read data: captured from pre-write state on the hit edge. The counter value read is the value at the request cycle.
- sel=0 write: acked, no change. Exception: an MBOX_DATA write with sel[0]=0 does not push.
- FIFO: push and pop cannot coincide, since the bus is single-master with one access in flight. Pointers wrap modulo FIFO_DEPTH. Full when level==FIFO_DEPTH.
- Reset mid-access: ack drops immediately; FIFO is emptied; any pending write is lost.

Decomposition:
- Package debug_reg_bank_pkg holds:
  - Offset constants: OFS_REG0, OFS_MBOX_DATA, OFS_MBOX_STAT, OFS_CYCLE_CNT, OFS_CTRL.
  - Status bit indices: STAT_EMPTY, STAT_FULL, STAT_OVF.
  - Ctrl bit indices: CTRL_EN, CTRL_CLR.
- One sub-module, debug_mbox_fifo: parametrised DEPTH×8 synchronous FIFO with push, pop, dout, level, full and empty. Same clock and asynchronous reset as the bank.

Test Plan:
- Reset value: reset with REG0_RST=1, then read 0x00 and 0x04 -> 0x1 and 0x0. Each ack lasts 1 cycle, 1 cycle after stb. CYCLE_CNT at 0x48 is nonzero and increasing.
- Byte enables: write 0x04 = 0xAABBCCDD sel=4'b0101 after 0 -> read 0x00BB00DD. dbg_regs_o[63:32] matches.
- Mailbox overflow and drain (FIFO_DEPTH=8):
  - Push 'H','i' -> STAT level=2, empty=0.
  - Pops return 0x8000_0048, 0x8000_0069, then 0x0.
  - Push 9 bytes -> full=1, ovf=1, level=8, and the 9th byte is lost.
  - W1C bit 18 -> ovf=0.
- Counter control:
  - Write CTRL=0 -> two reads of 0x48 are equal.
  - Write CTRL=0x2 -> counter reads 0.
  - Write 0x48=0xFFFF_FFFE with en=1 -> wraps to small values.
- Decode: read offset 0x20 (NUM_REGS=2) -> ack, data 0. Access with adr[31:8]!=base -> no ack within 4 cycles. dat_o=0 whenever ack=0.
- Reset mid-access: assert wb_rst_i with 3 bytes queued and stb high -> ack=0 immediately, level=0 after release.
